// File: rtl/uart_tx_burst.sv
// UART transmitter that serialises a burst of up to NUM_WORDS words taken from one stream beat.
// Latency: start bit appears on tx from the accepting edge; done pulses as the last stop bit ends.
// Backpressure: s_ready is high only in IDLE, so a beat waits until the previous burst has finished.
module uart_tx_burst #(
  parameter int CLOCKS_PER_PULSE = 4,
  parameter int BITS_PER_WORD    = 8,
  parameter int NUM_WORDS        = 3,
  parameter int PARITY           = 0,
  parameter int STOP_BITS        = 1
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic [NUM_WORDS*BITS_PER_WORD-1:0]   s_data,
  input  logic [$clog2(NUM_WORDS+1)-1:0]       s_len,
  output logic                                 tx,
  output logic                                 busy,
  output logic                                 done
);

  localparam int DW = NUM_WORDS * BITS_PER_WORD;
  localparam int LW = $clog2(NUM_WORDS + 1);
  localparam int CW = $clog2(CLOCKS_PER_PULSE);
  localparam int BW = $clog2(BITS_PER_WORD);
  localparam int WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_burst: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_burst: STOP_BITS must be 1 or 2");
  end
  if (CLOCKS_PER_PULSE < 2) begin : g_bad_cpp
    $error("uart_tx_burst: CLOCKS_PER_PULSE must be at least 2");
  end
  if (BITS_PER_WORD < 5 || BITS_PER_WORD > 9) begin : g_bad_bpw
    $error("uart_tx_burst: BITS_PER_WORD must be 5..9");
  end
  if (NUM_WORDS < 1) begin : g_bad_words
    $error("uart_tx_burst: NUM_WORDS must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   c_clocks, c_clocks_nxt;
  logic [BW-1:0]   c_bits, c_bits_nxt;
  logic [WW-1:0]   c_words, c_words_nxt;
  logic [LW-1:0]   len_q, len_nxt;
  // Remaining words of the burst; the word on the line always sits in the low BITS_PER_WORD bits.
  logic [DW-1:0]   data_q, data_nxt;
  logic            done_nxt;
  logic            tx_nxt;
  logic            bit_end;
  logic [BITS_PER_WORD-1:0] word_nxt;
  logic            par_nxt;

  assign s_ready = (state == S_IDLE);
  assign busy    = (state != S_IDLE);
  assign bit_end = (c_clocks == CW'(CLOCKS_PER_PULSE - 1));

  // Next-state, counter and data-buffer logic; tx is derived from the next state so it can be registered.
  always_comb begin
    state_nxt    = state;
    c_clocks_nxt = c_clocks;
    c_bits_nxt   = c_bits;
    c_words_nxt  = c_words;
    len_nxt      = len_q;
    data_nxt     = data_q;
    done_nxt     = 1'b0;

    case (state)
      S_IDLE: begin
        if (s_valid) begin
          data_nxt     = s_data;
          c_clocks_nxt = '0;
          c_bits_nxt   = '0;
          c_words_nxt  = '0;
          if (s_len == '0) begin
            // Empty beat: consumed with no line activity, completion reported next cycle.
            done_nxt = 1'b1;
          end else begin
            len_nxt   = (s_len > LW'(NUM_WORDS)) ? LW'(NUM_WORDS) : s_len;
            state_nxt = S_START;
          end
        end
      end

      S_START: begin
        if (bit_end) begin
          c_clocks_nxt = '0;
          state_nxt    = S_DATA;
        end else begin
          c_clocks_nxt = c_clocks + CW'(1);
        end
      end

      S_DATA: begin
        if (bit_end) begin
          c_clocks_nxt = '0;
          if (c_bits == BW'(BITS_PER_WORD - 1)) begin
            c_bits_nxt = '0;
            state_nxt  = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            c_bits_nxt = c_bits + BW'(1);
          end
        end else begin
          c_clocks_nxt = c_clocks + CW'(1);
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          c_clocks_nxt = '0;
          state_nxt    = S_STOP;
        end else begin
          c_clocks_nxt = c_clocks + CW'(1);
        end
      end

      S_STOP: begin
        if (bit_end) begin
          c_clocks_nxt = '0;
          if (c_bits == BW'(STOP_BITS - 1)) begin
            c_bits_nxt = '0;
            if (LW'(c_words) + LW'(1) == len_q) begin
              c_words_nxt = '0;
              state_nxt   = S_IDLE;
              done_nxt    = 1'b1;
            end else begin
              // Next word follows immediately with no idle gap.
              c_words_nxt = c_words + WW'(1);
              data_nxt    = data_q >> BITS_PER_WORD;
              state_nxt   = S_START;
            end
          end else begin
            c_bits_nxt = c_bits + BW'(1);
          end
        end else begin
          c_clocks_nxt = c_clocks + CW'(1);
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Line level for the next cycle, chosen from the state we are about to enter.
  always_comb begin
    word_nxt = data_nxt[BITS_PER_WORD-1:0];
    par_nxt  = (PARITY == 2) ? ~(^word_nxt) : (^word_nxt);
    tx_nxt   = 1'b1;
    case (state_nxt)
      S_IDLE:   tx_nxt = 1'b1;
      S_START:  tx_nxt = 1'b0;
      S_DATA:   tx_nxt = word_nxt[c_bits_nxt];
      S_PARITY: tx_nxt = par_nxt;
      S_STOP:   tx_nxt = 1'b1;
      default:  tx_nxt = 1'b1;
    endcase
  end

  // State, counters, buffer and registered outputs; reset aborts any frame and idles the line.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      c_clocks <= '0;
      c_bits   <= '0;
      c_words  <= '0;
      len_q    <= '0;
      data_q   <= '0;
      done     <= 1'b0;
      tx       <= 1'b1;
    end else begin
      state    <= state_nxt;
      c_clocks <= c_clocks_nxt;
      c_bits   <= c_bits_nxt;
      c_words  <= c_words_nxt;
      len_q    <= len_nxt;
      data_q   <= data_nxt;
      done     <= done_nxt;
      tx       <= tx_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_burst.sv
// Self-checking bench for uart_tx_burst: random and directed bursts against a frame-level model.
// Latency: expects start bit in the cycle after acceptance and done after len*frame*cpp cycles.
// Backpressure: checks s_ready at each offer and the one idle cycle between held-valid bursts.
module tb_uart_tx_burst;

  localparam int CPP = 4;
  localparam int BPW = 8;
  localparam int NW  = 3;
  localparam int PAR = 2;
  localparam int SB  = 2;
  localparam int DW  = NW * BPW;
  localparam int LW  = $clog2(NW + 1);

  logic          clk;
  logic          rstn;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic [LW-1:0] s_len;
  logic          tx;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;
  bit exp_q[$];

  uart_tx_burst #(
    .CLOCKS_PER_PULSE(CPP),
    .BITS_PER_WORD(BPW),
    .NUM_WORDS(NW),
    .PARITY(PAR),
    .STOP_BITS(SB)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .s_len(s_len),
    .tx(tx),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected line bits for a burst, one entry per bit-time.
  function automatic void build(input logic [DW-1:0] d, input int n);
    logic [DW-1:0]  t;
    logic [BPW-1:0] w;
    bit             p;
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      t = d >> (k * BPW);
      w = t[BPW-1:0];
      exp_q.push_back(1'b0);
      for (int b = 0; b < BPW; b++) exp_q.push_back(w[b]);
      if (PAR != 0) begin
        p = ($countones(w) % 2) == 1;
        if (PAR == 2) p = !p;
        exp_q.push_back(p);
      end
      for (int s = 0; s < SB; s++) exp_q.push_back(1'b1);
    end
  endfunction

  // Offer one beat at a negedge; returns at the negedge following the accepting edge with s_valid low.
  task automatic accept(input logic [DW-1:0] d, input logic [LW-1:0] len);
    @(negedge clk);
    chk("done_idle", done, 0);
    s_valid = 1'b1;
    s_data  = d;
    s_len   = len;
    chk("s_ready_offer", s_ready, 1);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Called at the first negedge after acceptance; ends at the negedge of the done cycle.
  task automatic run_burst(input logic [DW-1:0] d, input int len);
    int n;
    int dur;
    n = (len > NW) ? NW : len;
    build(d, n);
    dur = exp_q.size() * CPP;
    chk("frame_len", dur, n * (1 + BPW + (PAR != 0 ? 1 : 0) + SB) * CPP);
    for (int i = 0; i < dur; i++) begin
      chk("tx_bit", tx, exp_q[i / CPP]);
      chk("busy_on", busy, 1);
      chk("done_early", done, 0);
      @(negedge clk);
    end
    chk("done_pulse", done, 1);
    chk("busy_end", busy, 0);
    chk("tx_end", tx, 1);
    chk("s_ready_end", s_ready, 1);
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] d2;
    logic [LW-1:0] len;

    rstn    = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_len   = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_ready", s_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rstn = 1'b1;

    // Quiet line after reset.
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("quiet_tx", tx, 1);
      chk("quiet_ready", s_ready, 1);
      chk("quiet_busy", busy, 0);
      chk("quiet_done", done, 0);
    end

    // Three words 0x00/0xFF/0x3C, 144 cycles with odd parity and two stop bits.
    d = 24'h3CFF00;
    accept(d, 2'd3);
    run_burst(d, 3);

    // Single word 0xA5.
    d = 24'h0000A5;
    accept(d, 2'd1);
    run_burst(d, 1);

    // Partial burst: only words 0 and 1.
    d = 24'h123456;
    accept(d, 2'd2);
    run_burst(d, 2);

    // Empty beat: done next cycle, line stays high.
    d = 24'hFFFFFF;
    accept(d, 2'd0);
    run_burst(d, 0);

    // Inputs changed after acceptance must not affect the burst.
    d = 24'h5A0FC3;
    accept(d, 2'd3);
    s_data = ~d;
    s_len  = 2'd1;
    run_burst(d, 3);

    // Reset in the middle of word 1 data bits.
    d = 24'hA1B2C3;
    accept(d, 2'd3);
    repeat ((1 + BPW + 1 + SB) * CPP + 3 * CPP) @(negedge clk);
    chk("mid_busy", busy, 1);
    rstn = 1'b0;
    #1;
    chk("abort_tx", tx, 1);
    chk("abort_busy", busy, 0);
    chk("abort_ready", s_ready, 1);
    chk("abort_done", done, 0);
    @(negedge clk);
    rstn = 1'b1;
    d = 24'h0F1E2D;
    accept(d, 2'd3);
    run_burst(d, 3);

    // s_valid held high: second burst starts after exactly one idle cycle.
    d  = 24'h00C381;
    d2 = 24'h00667E;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_len   = 2'd2;
    @(posedge clk);
    @(negedge clk);
    run_burst(d, 2);
    s_data = d2;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    run_burst(d2, 2);

    // Randomised bursts with random idle gaps and post-acceptance input churn.
    for (int r = 0; r < 12; r++) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        chk("gap_tx", tx, 1);
        chk("gap_busy", busy, 0);
      end
      d   = DW'($urandom);
      len = LW'($urandom_range(0, NW));
      accept(d, len);
      s_data = DW'($urandom);
      s_len  = LW'($urandom);
      run_burst(d, int'(len));
    end

    @(negedge clk);
    chk("final_done", done, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
